// File: rtl/data_mem_lsu_pkg.sv
// Shared load/store definitions: RISC-V funct3 access codes, default data width
// and the access-size helper used by the LSU and the cache refill path.
package data_mem_lsu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes; 0 marks a code with no defined size.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 4'd1;
            F3_H, F3_HU: return 4'd2;
            F3_W, F3_WU: return 4'd4;
            F3_D:        return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response handshake between the MEM stage (master) and the data memory
// LSU (slave).
interface data_mem_lsu_if import data_mem_lsu_pkg::*; #(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int ADDR_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_lsu_load_align.sv
// Combinational load alignment: shifts the addressed lanes of a memory word down
// to bit 0 and sign/zero extends according to funct3.
module mem_load_align import data_mem_lsu_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0]            word,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [2:0]                 funct3,
    output logic [XLEN-1:0]            result
);

    logic [XLEN-1:0] shifted;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        shifted = word >> {offset, 3'b000};
        result  = '0;
        case (funct3)
            F3_B:    result = XLEN'($signed(shifted[7:0]));
            F3_BU:   result = XLEN'(shifted[7:0]);
            F3_H:    result = XLEN'($signed(shifted[15:0]));
            F3_HU:   result = XLEN'(shifted[15:0]);
            F3_W:    result = XLEN'($signed(shifted[31:0]));
            F3_WU:   result = XLEN'(shifted[31:0]);
            F3_D:    result = shifted;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory load/store unit: byte-lane RAM with funct3 sized accesses, legality
// and range checks, and a single registered response slot with back-pressure.
module data_mem_lsu import data_mem_lsu_pkg::*; #(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input logic           clk,
    input logic           rst,
    data_mem_lsu_if.slave bus
);

    localparam int NB     = XLEN / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = OFF_W + IDX_W;

    logic [XLEN-1:0]  mem [DEPTH];

    logic             accept;
    logic             f3_ok;
    logic             align_ok;
    logic             range_ok;
    logic             req_err;
    logic [3:0]       size;
    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [NB-1:0]    lane_mask;
    logic [NB-1:0]    byte_en;
    logic [XLEN-1:0]  wdata_lanes;
    logic [XLEN-1:0]  rd_word;
    logic [XLEN-1:0]  load_val;

    assign offset = bus.req_addr[OFF_W-1:0];
    assign index  = bus.req_addr[HI_LSB-1:OFF_W];

    // Any set address bit above the word index lies beyond DEPTH.
    generate
        if (ADDR_W > HI_LSB) begin : g_hi_bits
            assign range_ok = ~|bus.req_addr[ADDR_W-1:HI_LSB];
        end else begin : g_no_hi_bits
            assign range_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        size  = size_bytes(bus.req_funct3);
        f3_ok = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = !bus.req_we;
            F3_D:             f3_ok = (XLEN == 64);
            F3_WU:            f3_ok = (XLEN == 64) && !bus.req_we;
            default:          f3_ok = 1'b0;
        endcase
        align_ok    = (offset & OFF_W'(size - 4'd1)) == '0;
        req_err     = !(f3_ok && align_ok && range_ok);
        lane_mask   = NB'((16'd1 << size) - 16'd1);
        byte_en     = lane_mask << offset;
        wdata_lanes = bus.req_wdata << {offset, 3'b000};
    end

    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.req_ready = !bus.resp_valid || bus.resp_ready;

    // NOTE: the storage array has no reset branch; resetting it would block RAM inference.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) mem[index][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
            end
        end
    end

    assign rd_word = mem[index];

    mem_load_align #(.XLEN(XLEN)) u_load_align (
        .word   (rd_word),
        .offset (offset),
        .funct3 (bus.req_funct3),
        .result (load_val)
    );

    // A new accept always overwrites the slot; it can only happen when the old
    // response is absent or being consumed in the same cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else if (accept) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= req_err;
            bus.resp_rdata <= (req_err || bus.req_we) ? '0 : load_val;
        end else if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised successor to the core's single-port data memory, generalised in data width and depth.
- Adds byte/half/word (and dword at XLEN=64) loads/stores with RISC-V funct3 encoding, byte-lane write enables and sign/zero extension.
- Adds misalignment and range checking, plus a valid/ready request/response handshake with a 1-cycle registered response that holds under back-pressure.
- Sits between the MEM stage and on-chip data RAM; every accepted request returns exactly one response, stores included.

Parameters:
XLEN, 32, data width; legal values 32 or 64
DEPTH, 1024, memory depth in XLEN-wide words; power of two
ADDR_W, 32, byte-address width of req_addr

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 access size/sign
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned (low bytes used)
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  XLEN  load result, extended; 0 for stores and errors
resp_err  out  1  misaligned, illegal funct3 or out-of-range access

Behaviour:
- Reset: async on rst low. resp_valid=0, resp_rdata=0, resp_err=0. A pending response is discarded. Memory contents are not reset.
- req_ready = !resp_valid || resp_ready, combinational. Single-entry response register; no other buffering.
- Latency: request accepted at edge N; response visible after edge N, i.e. valid in cycle N+1. Back-to-back throughput is 1/cycle while resp_ready=1.
- Response hold: while resp_valid && !resp_ready, resp_rdata/resp_err are stable and no request is accepted.
- Response register update:
  - Accept without consume of the old response: load new response.
  - Consume without accept: resp_valid goes to 0 next edge.
  - Simultaneous consume and accept: load new response; resp_valid stays 1.
- funct3 legality:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
  - 011/110 are legal only when XLEN=64. Any other code is illegal and sets resp_err=1.
- Alignment: the byte address must be a multiple of the access size. Otherwise resp_err=1.
- Range: word index = req_addr >> log2(XLEN/8). If index >= DEPTH, or any req_addr bit above the index bits is 1, resp_err=1.
- Error handling: any error means no memory write, resp_rdata=0.
- Stores: write only the addressed byte lanes.
  - Lane offset = low address bits.
  - SB writes 1 lane, SH 2, SW 4, SD 8.
  - Data comes from the low bytes of req_wdata, shifted to the lane.
  - Write occurs at the accept edge.
  - Response: resp_err as checked, resp_rdata=0.
- Loads: read the word at the accept edge, extract lanes at the offset, then extend.
  - Signed variants (LB/LH/LW at XLEN=64) sign-extend from the top bit.
  - U variants zero-extend.
  - LW at XLEN=32 and LD are unextended.
- Ordering: a store accepted at edge N is visible to a load accepted at edge N+1 or later (read-after-write correct, no forwarding path needed since accesses are serialised).
- No internal state machine beyond the response valid flag; implementation must not add bubbles.

Decomposition:
- Shared package (core-wide, e.g. core_pkg) holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - Default XLEN.
  - Function size_bytes(funct3).
- Sub-module mem_load_align: combinational; takes word, byte offset and funct3, returns the extended result. Reused later by the cache refill path.
- Storage array, byte-enable generation, checks and response register live in data_mem_lsu.

Test Plan:
- XLEN=32. SW 0xDEADBEEF @0x10, then LW @0x10, LB @0x13, LBU @0x13, LH @0x12 -> responses 0xDEADBEEF, 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD; all resp_err=0; 1-cycle latency each.
- SB 0x5A @0x11 over word 0xDEADBEEF @0x10, then LW @0x10 -> 0xDEAD5AEF; other lanes untouched.
- Misaligned LW @0x12 and SH @0x21 -> resp_err=1, resp_rdata=0; subsequent LW @0x20 unchanged from before.
- Back-pressure: resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable; resp_ready=1 -> consume and accept in the same cycle; resp_valid stays 1; no lost or duplicated responses over 100 random back-to-back requests, scoreboard-checked.
- Range/illegal: LW @ DEPTH*4 -> resp_err=1; funct3=011 at XLEN=32 -> resp_err=1. XLEN=64: SD 0x8000000000000001 @0x8, LW @0xC -> 0xFFFFFFFF80000000; LWU @0xC -> 0x0000000080000000.
- Reset mid-operation: assert rst low asynchronously between edges while resp_valid=1 -> resp_valid, resp_rdata, resp_err go to 0 immediately. After release, a previously stored word still reads back correctly.
